// File: rtl/tanh_lut_fetcher_if.sv
// Argument stream in and interpolator bundle out for the tanh table fetcher.
interface tanh_lut_fetcher_if;
  logic               in_valid;
  logic               in_ready;
  logic signed [31:0] z_in;
  logic               out_valid;
  logic               out_ready;
  logic signed [31:0] z_value;
  logic signed [31:0] base;
  logic signed [31:0] next_data;
  logic signed [31:0] addr;
  logic               saturated;

  modport master (
    output in_valid, z_in, out_ready,
    input  in_ready, out_valid, z_value, base, next_data, addr, saturated
  );

  modport slave (
    input  in_valid, z_in, out_ready,
    output in_ready, out_valid, z_value, base, next_data, addr, saturated
  );
endinterface

// File: rtl/tanh_lut_fetcher.sv
// Clamps a Q4.28 argument and reads the two bracketing tanh samples; out_valid rises 4 cycles
// after accept, one z in flight, bundle held while out_ready is low.
module tanh_lut_fetcher #(
  parameter logic signed [31:0] Z_MIN      = -32'sh4000_0000,
  parameter int                 STEP_SHIFT = 26,
  parameter int                 DEPTH      = 33,
  parameter int                 IDX_W      = 6
) (
  input  logic               clk,
  input  logic               rst,
  tanh_lut_fetcher_if.slave  bus,
  output logic               mem_en,
  output logic [IDX_W-1:0]   mem_addr,
  input  logic signed [31:0] mem_rdata
);

  localparam logic signed [32:0] Z_MIN_X = {Z_MIN[31], Z_MIN};
  localparam logic signed [32:0] SPAN    = 33'(DEPTH - 1) << STEP_SHIFT;
  localparam logic signed [32:0] Z_MAX_X = Z_MIN_X + SPAN;
  localparam logic signed [32:0] Z_TOP_X = Z_MAX_X - 33'sd1;
  localparam logic signed [31:0] Z_TOP   = Z_TOP_X[31:0];

  typedef enum logic [2:0] {IDLE, FETCH0, FETCH1, WAIT1, DONE} state_t;

  state_t             state;
  logic               in_ready_q;
  logic               out_valid_q;
  logic signed [31:0] z_value_q;
  logic signed [31:0] base_q;
  logic signed [31:0] next_data_q;
  logic signed [31:0] addr_q;
  logic               saturated_q;
  logic signed [31:0] zc;
  logic [IDX_W-1:0]   idx;

  logic signed [32:0] z_ext;
  logic signed [31:0] zc_c;
  logic               sat_c;
  logic signed [32:0] offset;
  logic [IDX_W-1:0]   idx_c;
  logic [31:0]        addr_c;

  // Widen by one bit so arguments near the 32-bit extremes compare without wrapping.
  always_comb begin
    z_ext = {bus.z_in[31], bus.z_in};
    zc_c  = bus.z_in;
    sat_c = 1'b0;
    if (z_ext < Z_MIN_X) begin
      zc_c  = Z_MIN;
      sat_c = 1'b1;
    end else if (z_ext >= Z_MAX_X) begin
      zc_c  = Z_TOP;
      sat_c = 1'b1;
    end
    offset = {zc_c[31], zc_c} - Z_MIN_X;
    idx_c  = IDX_W'(offset >> STEP_SHIFT);
    addr_c = Z_MIN + (32'(idx) << STEP_SHIFT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      mem_en      <= 1'b0;
      mem_addr    <= '0;
      z_value_q   <= '0;
      base_q      <= '0;
      next_data_q <= '0;
      addr_q      <= '0;
      saturated_q <= 1'b0;
      zc          <= '0;
      idx         <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            zc          <= zc_c;
            idx         <= idx_c;
            saturated_q <= sat_c;
            mem_en      <= 1'b1;
            mem_addr    <= idx_c;
            in_ready_q  <= 1'b0;
            state       <= FETCH0;
          end
        end
        FETCH0: begin
          mem_addr <= idx + IDX_W'(1);
          state    <= FETCH1;
        end
        FETCH1: begin
          // Read of idx issued at the end of FETCH0 lands on the bus now.
          base_q <= mem_rdata;
          mem_en <= 1'b0;
          state  <= WAIT1;
        end
        WAIT1: begin
          next_data_q <= mem_rdata;
          z_value_q   <= zc;
          addr_q      <= addr_c;
          out_valid_q <= 1'b1;
          state       <= DONE;
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.z_value   = z_value_q;
  assign bus.base      = base_q;
  assign bus.next_data = next_data_q;
  assign bus.addr      = addr_q;
  assign bus.saturated = saturated_q;

endmodule

// File: tb/tb_tanh_lut_fetcher.sv
// Directed bench for tanh_lut_fetcher against a table holding RAM[k] = k*16.
module tb_tanh_lut_fetcher;
  logic        clk = 1'b0;
  logic        rst;
  logic        mem_en;
  logic [5:0]  mem_addr;
  logic [31:0] mem_rdata = '0;
  logic [31:0] ram [0:63];
  int          errors = 0;
  int          checks = 0;

  tanh_lut_fetcher_if bus ();

  tanh_lut_fetcher dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .mem_en    (mem_en),
    .mem_addr  (mem_addr),
    .mem_rdata (mem_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (mem_en) mem_rdata <= ram[mem_addr];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // One transaction: accept, two fetch cycles, wait, then DONE held for 'stall' cycles.
  // With hold_next set, the next argument is driven during the stall and left asserted.
  task automatic run_z(input logic [31:0] z, input logic [31:0] exp_zv, input logic [31:0] exp_addr,
                       input int idx, input logic exp_sat, input int stall,
                       input logic hold_next, input logic [31:0] next_z);
    check("idle_in_ready", 32'(bus.in_ready), 32'd1);
    bus.in_valid = 1'b1;
    bus.z_in     = z;
    tick();
    bus.in_valid = 1'b0;
    bus.z_in     = 32'hDEAD_BEEF;
    check("fetch0_mem_en", 32'(mem_en), 32'd1);
    check("fetch0_mem_addr", 32'(mem_addr), 32'(idx));
    check("fetch0_in_ready", 32'(bus.in_ready), 32'd0);
    tick();
    check("fetch1_mem_en", 32'(mem_en), 32'd1);
    check("fetch1_mem_addr", 32'(mem_addr), 32'(idx + 1));
    tick();
    check("wait1_mem_en", 32'(mem_en), 32'd0);
    check("wait1_out_valid", 32'(bus.out_valid), 32'd0);
    tick();
    check("done_out_valid", 32'(bus.out_valid), 32'd1);
    check("z_value", bus.z_value, exp_zv);
    check("addr", bus.addr, exp_addr);
    check("base", bus.base, 32'(idx * 16));
    check("next_data", bus.next_data, 32'((idx + 1) * 16));
    check("saturated", 32'(bus.saturated), 32'(exp_sat));
    for (int s = 0; s < stall; s++) begin
      bus.in_valid = hold_next;
      bus.z_in     = next_z;
      tick();
      check("stall_out_valid", 32'(bus.out_valid), 32'd1);
      check("stall_z_value", bus.z_value, exp_zv);
      check("stall_base", bus.base, 32'(idx * 16));
      check("stall_next_data", bus.next_data, 32'((idx + 1) * 16));
      check("stall_addr", bus.addr, exp_addr);
      check("stall_in_ready", 32'(bus.in_ready), 32'd0);
      check("stall_mem_en", 32'(mem_en), 32'd0);
    end
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    check("post_hs_out_valid", 32'(bus.out_valid), 32'd0);
    check("post_hs_in_ready", 32'(bus.in_ready), 32'd1);
  endtask

  initial begin
    for (int k = 0; k < 64; k++) ram[k] = 32'(k * 16);
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.z_in      = '0;
    tick();
    tick();
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_mem_en", 32'(mem_en), 32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'd0);
    check("rst_z_value", bus.z_value, 32'd0);
    check("rst_base", bus.base, 32'd0);
    check("rst_next_data", bus.next_data, 32'd0);
    check("rst_addr", bus.addr, 32'd0);
    check("rst_saturated", 32'(bus.saturated), 32'd0);
    rst = 1'b0;
    tick();

    // 0.5, -5.0, then a non-grid point stalled 3 cycles with +4.0 queued behind it.
    run_z(32'h0800_0000, 32'h0800_0000, 32'h0800_0000, 18, 1'b0, 0, 1'b0, 32'h0);
    run_z(32'hB000_0000, 32'hC000_0000, 32'hC000_0000, 0, 1'b1, 0, 1'b0, 32'h0);
    run_z(32'hC400_0001, 32'hC400_0001, 32'hC400_0000, 1, 1'b0, 3, 1'b1, 32'h4000_0000);
    run_z(32'h4000_0000, 32'h3FFF_FFFF, 32'h3C00_0000, 31, 1'b1, 0, 1'b0, 32'h0);

    // Abort mid-FETCH1: nothing may be emitted for the aborted argument.
    bus.in_valid = 1'b1;
    bus.z_in     = 32'h0800_0000;
    tick();
    bus.in_valid = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    check("abort_in_ready", 32'(bus.in_ready), 32'd1);
    check("abort_out_valid", 32'(bus.out_valid), 32'd0);
    check("abort_mem_en", 32'(mem_en), 32'd0);
    for (int c = 0; c < 4; c++) begin
      tick();
      check("abort_quiet", 32'(bus.out_valid), 32'd0);
    end

    // Domain edges: last in-range point, exact lower bound, just below, most negative.
    run_z(32'h3FFF_FFFF, 32'h3FFF_FFFF, 32'h3C00_0000, 31, 1'b0, 0, 1'b0, 32'h0);
    run_z(32'hC000_0000, 32'hC000_0000, 32'hC000_0000, 0, 1'b0, 0, 1'b0, 32'h0);
    run_z(32'hBFFF_FFFF, 32'hC000_0000, 32'hC000_0000, 0, 1'b1, 0, 1'b0, 32'h0);
    run_z(32'h8000_0000, 32'hC000_0000, 32'hC000_0000, 0, 1'b1, 1, 1'b0, 32'h0);
    run_z(32'h7FFF_FFFF, 32'h3FFF_FFFF, 32'h3C00_0000, 31, 1'b1, 0, 1'b0, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
